// File: rtl/nmr_tx_pkg.sv
// Shared types and helpers for the NMR transmit pulse sequencer:
// FSM state encoding, phase codes, sample defaults and saturating negate.
package nmr_tx_pkg;

  localparam int SAMPLES_DEF = 4;
  localparam int BITS_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_PULSE,
    ST_TAIL,
    ST_DELAY
  } tx_state_e;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  // Two's-complement negate of a w-bit value (w <= 31) that clamps the
  // most negative code to the most positive one instead of wrapping.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x, input int w);
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    lo = -(32'sd1 <<< (w - 1));
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return (x == lo) ? hi : -x;
  endfunction

endpackage

// File: rtl/tx_phase_amp.sv
// One transmit lane: rotate by the phase code and gate (stage 1), then scale
// by the unsigned Q0.16 amplitude and keep product bits [BITS+15:16] (stage 2).
module tx_phase_amp
  import nmr_tx_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      phase,
  input  logic [15:0]     amp,
  input  logic [BITS-1:0] i_in,
  input  logic [BITS-1:0] q_in,
  output logic [BITS-1:0] y
);

  logic signed [BITS-1:0]  rot_d, rot_q;
  logic signed [BITS-1:0]  y_d, y_q;
  logic signed [BITS+17:0] prod;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rot_d = '0;
    if (en) begin
      case (phase)
        PH_90:   rot_d = BITS'(sat_neg(32'($signed(q_in)), BITS));
        PH_180:  rot_d = BITS'(sat_neg(32'($signed(i_in)), BITS));
        PH_270:  rot_d = q_in;
        default: rot_d = i_in;
      endcase
    end
    prod = (BITS+18)'(rot_q) * (BITS+18)'($signed({1'b0, amp}));
    // Arithmetic shift truncates toward minus infinity.
    y_d  = BITS'(prod >>> 16);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q <= '0;
      y_q   <= '0;
    end else begin
      rot_q <= rot_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/tx_pulse_sequencer.sv
// NMR transmit pulse-train sequencer: gated, phase-cycled, amplitude-scaled
// DDS samples to the DAC. Define TX_RAMP_EN for linear edge ramps (+1 cycle).
module tx_pulse_sequencer
  import nmr_tx_pkg::*;
#(
  parameter int SAMPLES   = SAMPLES_DEF,
  parameter int BITS      = BITS_DEF,
  parameter int CNT_W     = 32,
  parameter int GATE_LEAD = 8,
  parameter int GATE_TAIL = 4,
  parameter int RAMP_LEN  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        pulse_len,
  input  logic [CNT_W-1:0]        delay_len,
  input  logic [15:0]             num_pulses,
  input  logic [1:0]              phase_sel,
  input  logic [15:0]             amplitude,
  input  logic                    dds_val,
  input  logic [SAMPLES*BITS-1:0] dds_i,
  input  logic [SAMPLES*BITS-1:0] dds_q,
  output logic [SAMPLES*BITS-1:0] dac_out,
  output logic                    dac_valid,
  output logic                    tx_gate,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun
);

  if (GATE_LEAD < 1 || GATE_TAIL < 2 || RAMP_LEN < 1 || (RAMP_LEN & (RAMP_LEN - 1)) != 0) begin : g_bad_cfg
    $error("tx_pulse_sequencer: illegal GATE_LEAD, GATE_TAIL or RAMP_LEN");
  end

`ifdef TX_RAMP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, plen_q, plen_d, dlen_q, dlen_d;
  logic [15:0]        left_q, left_d, amp_q, amp_d;
  logic [1:0]         phase_q, phase_d;
  logic               busy_q, busy_d, gate_q, gate_d, done_q, done_d;
  logic               underrun_q, underrun_d;
  logic [LAT-1:0]     vpipe_q, vpipe_d;
  logic               enter_lead;
  logic               rf_en;

  assign rf_en = (state_q == ST_PULSE) && dds_val;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    plen_d     = plen_q;
    dlen_d     = dlen_q;
    left_d     = left_q;
    amp_d      = amp_q;
    phase_d    = phase_q;
    done_d     = 1'b0;
    underrun_d = underrun_q || ((state_q == ST_PULSE) && !dds_val);
    enter_lead = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        underrun_d = 1'b0;
        plen_d     = pulse_len;
        dlen_d     = delay_len;
        left_d     = num_pulses;
        if (num_pulses == 16'd0) done_d = 1'b1;
        else                     enter_lead = 1'b1;
      end
      ST_LEAD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          if (plen_q == '0) begin
            state_d = ST_TAIL;
            cnt_d   = CNT_W'(GATE_TAIL - 1);
          end else begin
            state_d = ST_PULSE;
            cnt_d   = plen_q - CNT_W'(1);
          end
        end
      end
      ST_PULSE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_TAIL;
          cnt_d   = CNT_W'(GATE_TAIL - 1);
        end
      end
      ST_TAIL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          if (left_q <= 16'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            left_d = left_q - 16'd1;
            if (dlen_q == '0) begin
              enter_lead = 1'b1;
            end else begin
              state_d = ST_DELAY;
              cnt_d   = dlen_q - CNT_W'(1);
            end
          end
        end
      end
      ST_DELAY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) enter_lead = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Phase and amplitude are captured per pulse to allow phase cycling.
    if (enter_lead) begin
      state_d = ST_LEAD;
      cnt_d   = CNT_W'(GATE_LEAD - 1);
      phase_d = phase_sel;
      amp_d   = amplitude;
    end
    busy_d  = (state_d != ST_IDLE);
    gate_d  = (state_d == ST_LEAD) || (state_d == ST_PULSE) || (state_d == ST_TAIL);
    vpipe_d = {vpipe_q[LAT-2:0], (state_q == ST_PULSE)};
  end

  // NOTE: reset is synchronous and clears every control and pipeline flop so
  // a mid-train reset leaves all outputs at zero on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      plen_q     <= '0;
      dlen_q     <= '0;
      left_q     <= '0;
      amp_q      <= '0;
      phase_q    <= PH_0;
      busy_q     <= 1'b0;
      gate_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      vpipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      plen_q     <= plen_d;
      dlen_q     <= dlen_d;
      left_q     <= left_d;
      amp_q      <= amp_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      gate_q     <= gate_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      vpipe_q    <= vpipe_d;
    end
  end

  logic                    sub_en;
  logic [1:0]              sub_phase;
  logic [15:0]             sub_amp;
  logic [SAMPLES*BITS-1:0] sub_i, sub_q;

`ifdef TX_RAMP_EN
  localparam int RAMP_SH = $clog2(RAMP_LEN);

  logic [CNT_W-1:0]        k_up, k_down, k_min;
  logic [RAMP_SH:0]        fac;
  logic [RAMP_SH+16:0]     amp_scaled;
  logic                    pre_en_d, pre_en_q;
  logic [1:0]              pre_phase_d, pre_phase_q;
  logic [15:0]             pre_amp_d, pre_amp_q;
  logic [SAMPLES*BITS-1:0] pre_i_d, pre_i_q, pre_q_d, pre_q_q;

  // Envelope factor min(k_up, k_down, RAMP_LEN)/RAMP_LEN; a short pulse
  // naturally becomes a triangle.
  always_comb begin
    k_up        = plen_q - cnt_q;
    k_down      = cnt_q + CNT_W'(1);
    k_min       = (k_up < k_down) ? k_up : k_down;
    fac         = (k_min >= CNT_W'(RAMP_LEN)) ? (RAMP_SH+1)'(RAMP_LEN) : k_min[RAMP_SH:0];
    amp_scaled  = (RAMP_SH+17)'(amp_q) * (RAMP_SH+17)'(fac);
    pre_amp_d   = 16'(amp_scaled >> RAMP_SH);
    pre_en_d    = rf_en;
    pre_phase_d = phase_q;
    pre_i_d     = dds_i;
    pre_q_d     = dds_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_en_q    <= 1'b0;
      pre_phase_q <= PH_0;
      pre_amp_q   <= '0;
      pre_i_q     <= '0;
      pre_q_q     <= '0;
    end else begin
      pre_en_q    <= pre_en_d;
      pre_phase_q <= pre_phase_d;
      pre_amp_q   <= pre_amp_d;
      pre_i_q     <= pre_i_d;
      pre_q_q     <= pre_q_d;
    end
  end

  assign sub_en    = pre_en_q;
  assign sub_phase = pre_phase_q;
  assign sub_amp   = pre_amp_q;
  assign sub_i     = pre_i_q;
  assign sub_q     = pre_q_q;
`else
  assign sub_en    = rf_en;
  assign sub_phase = phase_q;
  assign sub_amp   = amp_q;
  assign sub_i     = dds_i;
  assign sub_q     = dds_q;
`endif

  for (genvar g = 0; g < SAMPLES; g++) begin : g_lane
    tx_phase_amp #(.BITS(BITS)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (sub_en),
      .phase (sub_phase),
      .amp   (sub_amp),
      .i_in  (sub_i[g*BITS +: BITS]),
      .q_in  (sub_q[g*BITS +: BITS]),
      .y     (dac_out[g*BITS +: BITS])
    );
  end

  assign dac_valid = vpipe_q[LAT-1];
  assign tx_gate   = gate_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_tx_pulse_sequencer.sv
// Self-checking bench for tx_pulse_sequencer (default build, TX_RAMP_EN undefined):
// a table of single/multi-pulse trains plus hand-written multi-cycle sequences.
module tb_tx_pulse_sequencer;

  localparam int SAMPLES = 4;
  localparam int BITS    = 16;
  localparam int CNT_W   = 32;
  localparam int GL      = 8;
  localparam int GT      = 4;
  localparam int LAT     = 2;

  logic                    clk = 1'b0;
  logic                    rst, start, dds_val;
  logic [CNT_W-1:0]        pulse_len, delay_len;
  logic [15:0]             num_pulses, amplitude;
  logic [1:0]              phase_sel;
  logic [SAMPLES*BITS-1:0] dds_i, dds_q, dac_out;
  logic                    dac_valid, tx_gate, busy, done, underrun;

  tx_pulse_sequencer #(
    .SAMPLES(SAMPLES), .BITS(BITS), .CNT_W(CNT_W),
    .GATE_LEAD(GL), .GATE_TAIL(GT), .RAMP_LEN(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pulse_len(pulse_len), .delay_len(delay_len),
    .num_pulses(num_pulses), .phase_sel(phase_sel), .amplitude(amplitude),
    .dds_val(dds_val), .dds_i(dds_i), .dds_q(dds_q), .dac_out(dac_out),
    .dac_valid(dac_valid), .tx_gate(tx_gate), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ph;
    logic [15:0] amp;
    logic [63:0] iv;
    logic [63:0] qv;
    logic [63:0] ev;
    int          plen;
    int          dlen;
    int          np;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic int lane(input logic [63:0] v, input int k);
    logic signed [15:0] s;
    s = v[k*16 +: 16];
    return int'(s);
  endfunction

  task automatic launch(input int np, input int plen, input int dlen, input logic [1:0] ph,
                        input logic [15:0] amp, input logic [63:0] iv, input logic [63:0] qv);
    @(negedge clk);
    start = 1'b1; num_pulses = 16'(np); pulse_len = CNT_W'(plen); delay_len = CNT_W'(dlen);
    phase_sel = ph; amplitude = amp; dds_i = iv; dds_q = qv; dds_val = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one train; loop index n is the cycle number with start sampled at cycle 0.
  task automatic run_train(input string tag, input vec_t v);
    int gate_cnt = 0, valid_cnt = 0, out_bad = 0, zero_bad = 0;
    int done_at = -1, first_valid = -1, busy1, busy_done = -1, und_done = -1;
    launch(v.np, v.plen, v.dlen, v.ph, v.amp, v.iv, v.qv);
    busy1 = int'(busy);
    for (int n = 1; n <= 1000; n++) begin
      if (tx_gate) gate_cnt++;
      if (dac_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = n;
        for (int k = 0; k < SAMPLES; k++)
          if (lane(dac_out, k) != lane(v.ev, k)) out_bad++;
      end else if (dac_out != '0) begin
        zero_bad++;
      end
      if (done) begin
        done_at = n; busy_done = int'(busy); und_done = int'(underrun);
        break;
      end
      @(negedge clk);
    end
    check({tag, " busy@1"}, busy1, 1);
    check({tag, " done_at"}, done_at, 1 + v.np * (GL + v.plen + GT) + (v.np - 1) * v.dlen);
    check({tag, " gate_cycles"}, gate_cnt, v.np * (GL + v.plen + GT));
    check({tag, " valid_cycles"}, valid_cnt, v.np * v.plen);
    check({tag, " first_valid"}, first_valid, (v.plen > 0) ? 1 + GL + LAT : -1);
    check({tag, " sample_errs"}, out_bad, 0);
    check({tag, " nonzero_idle"}, zero_bad, 0);
    check({tag, " busy@done"}, busy_done, 0);
    check({tag, " underrun@done"}, und_done, 0);
  endtask

  task automatic seq_zero_pulses();
    launch(0, 5, 0, 2'd0, 16'hFFFF, '0, '0);
    check("np0 done", int'(done), 1);
    check("np0 busy", int'(busy), 0);
    @(negedge clk);
    check("np0 done_once", int'(done), 0);
    check("np0 busy_after", int'(busy), 0);
    check("np0 gate", int'(tx_gate), 0);
  endtask

  task automatic seq_phase_cycle();
    int exp_ph [4] = '{500, -1000, -500, 1000};
    int runs = 0, vruns = 0, bad = 0, done_at = -1;
    logic gate_prev = 1'b0, valid_prev = 1'b0;
    launch(4, 4, 3, 2'd0, 16'h8000, pack4(1000, 1000, 1000, 1000), pack4(2000, 2000, 2000, 2000));
    for (int n = 1; n <= 500; n++) begin
      if (tx_gate && !gate_prev) runs++;
      if (dac_valid && !valid_prev) vruns++;
      gate_prev  = tx_gate;
      valid_prev = dac_valid;
      if (dac_valid && vruns >= 1 && vruns <= 4)
        for (int k = 0; k < SAMPLES; k++)
          if (lane(dac_out, k) != exp_ph[vruns-1]) bad++;
      if (done) begin done_at = n; break; end
      // Correct code only while the gate is off; junk while a pulse is live.
      phase_sel = tx_gate ? 2'(runs + 1) : 2'(runs);
      amplitude = tx_gate ? 16'h1234 : 16'h8000;
      @(negedge clk);
    end
    check("phase sample_errs", bad, 0);
    check("phase valid_runs", vruns, 4);
    check("phase gate_runs", runs, 4);
    check("phase done_at", done_at, 1 + 4 * (GL + 4 + GT) + 3 * 3);
  endtask

  task automatic seq_underrun();
    int done_at = -1, valid_cnt = 0, bad = 0, u11 = -1, u12 = -1, u_done = -1, expv;
    launch(1, 10, 0, 2'd0, 16'hFFFF, pack4(16384, 16384, 16384, 16384), '0);
    for (int n = 1; n <= 200; n++) begin
      if (n == 11) u11 = int'(underrun);
      if (n == 12) u12 = int'(underrun);
      if (dac_valid) begin
        valid_cnt++;
        expv = (n >= 13 && n <= 15) ? 0 : 16383;
        for (int k = 0; k < SAMPLES; k++)
          if (lane(dac_out, k) != expv) bad++;
      end
      if (done) begin done_at = n; u_done = int'(underrun); break; end
      dds_val = !(n >= 11 && n <= 13);
      @(negedge clk);
    end
    dds_val = 1'b1;
    check("underrun sample_errs", bad, 0);
    check("underrun valid_cycles", valid_cnt, 10);
    check("underrun done_at", done_at, 23);
    check("underrun before_drop", u11, 0);
    check("underrun set", u12, 1);
    check("underrun at_done", u_done, 1);
    repeat (3) @(negedge clk);
    check("underrun sticky_idle", int'(underrun), 1);
  endtask

  task automatic seq_reset_mid();
    int n_done = 0, n_busy = 0;
    launch(1, 10, 0, 2'd0, 16'hFFFF, pack4(16384, 16384, 16384, 16384), '0);
    dds_val = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dds_val = 1'b1;
    check("rstmid dac_out_nz", int'(dac_out != '0), 0);
    check("rstmid dac_valid", int'(dac_valid), 0);
    check("rstmid tx_gate", int'(tx_gate), 0);
    check("rstmid busy", int'(busy), 0);
    check("rstmid underrun", int'(underrun), 0);
    for (int n = 0; n < 40; n++) begin
      if (done) n_done++;
      if (busy) n_busy++;
      @(negedge clk);
    end
    check("rstmid no_done", n_done, 0);
    check("rstmid stays_idle", n_busy, 0);
  endtask

  task automatic seq_start_busy();
    int gate_cnt = 0, done_at = -1, done2 = -1, busy_cnt = 0;
    launch(1, 2, 0, 2'd0, 16'h8000, pack4(1000, 1000, 1000, 1000), '0);
    for (int n = 1; n <= 200; n++) begin
      if (tx_gate) gate_cnt++;
      if (done) begin done_at = n; break; end
      start      = (n == 5);
      num_pulses = (n == 5) ? 16'd3 : 16'd1;
      pulse_len  = (n == 5) ? CNT_W'(50) : CNT_W'(2);
      @(negedge clk);
    end
    check("busystart done_at", done_at, 1 + GL + 2 + GT);
    check("busystart gate_cycles", gate_cnt, GL + 2 + GT);
    // Back-to-back: start during the done cycle must be accepted.
    start = 1'b1; num_pulses = 16'd1; pulse_len = '0;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy", int'(busy), 1);
    check("b2b gate", int'(tx_gate), 1);
    for (int n = 1; n <= 200; n++) begin
      if (done) begin done2 = n; break; end
      @(negedge clk);
    end
    check("b2b done_at", done2, 1 + GL + GT);
    for (int n = 0; n < 20; n++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("b2b idle_after", busy_cnt, 0);
  endtask

  initial begin
    vecs[0] = '{ph: 2'd0, amp: 16'hFFFF, iv: pack4(16384, 16384, 16384, 16384), qv: '0,
                ev: pack4(16383, 16383, 16383, 16383), plen: 10, dlen: 0, np: 1};
    vecs[1] = '{ph: 2'd0, amp: 16'h8000, iv: pack4(1000, -1000, 2, -3), qv: pack4(77, 77, 77, 77),
                ev: pack4(500, -500, 1, -2), plen: 3, dlen: 0, np: 1};
    vecs[2] = '{ph: 2'd1, amp: 16'h8000, iv: pack4(5, 5, 5, 5), qv: pack4(2000, -2000, 32767, -32768),
                ev: pack4(-1000, 1000, -16384, 16383), plen: 1, dlen: 0, np: 1};
    vecs[3] = '{ph: 2'd2, amp: 16'hFFFF, iv: pack4(-32768, 32767, 0, 1), qv: '0,
                ev: pack4(32766, -32767, 0, -1), plen: 5, dlen: 0, np: 1};
    vecs[4] = '{ph: 2'd3, amp: 16'h4000, iv: pack4(1234, 1234, 1234, 1234), qv: pack4(4000, -4000, 7, 100),
                ev: pack4(1000, -1000, 1, 25), plen: 2, dlen: 0, np: 1};
    vecs[5] = '{ph: 2'd0, amp: 16'h0000, iv: pack4(5000, -5000, 32767, -32768), qv: '0,
                ev: '0, plen: 4, dlen: 0, np: 1};
    vecs[6] = '{ph: 2'd0, amp: 16'h0001, iv: pack4(32767, -32768, -1, 1), qv: '0,
                ev: pack4(0, -1, -1, 0), plen: 1, dlen: 0, np: 1};
    vecs[7] = '{ph: 2'd0, amp: 16'hFFFF, iv: pack4(16384, 16384, 16384, 16384), qv: '0,
                ev: '0, plen: 0, dlen: 0, np: 1};
    vecs[8] = '{ph: 2'd0, amp: 16'h8000, iv: pack4(1000, 1000, 1000, 1000), qv: '0,
                ev: pack4(500, 500, 500, 500), plen: 2, dlen: 0, np: 2};
    vecs[9] = '{ph: 2'd2, amp: 16'h8000, iv: pack4(1000, -1000, -32768, 0), qv: '0,
                ev: pack4(-500, 500, 16383, 0), plen: 1, dlen: 5, np: 3};

    rst = 1'b1; start = 1'b0; dds_val = 1'b0; pulse_len = '0; delay_len = '0;
    num_pulses = '0; phase_sel = '0; amplitude = '0; dds_i = '0; dds_q = '0;
    repeat (3) @(negedge clk);
    check("reset dac_out_nz", int'(dac_out != '0), 0);
    check("reset dac_valid", int'(dac_valid), 0);
    check("reset tx_gate", int'(tx_gate), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset underrun", int'(underrun), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 10; v++) run_train($sformatf("vec%0d", v), vecs[v]);

    seq_zero_pulses();
    seq_phase_cycle();
    seq_underrun();
    run_train("after_underrun", vecs[0]);
    seq_reset_mid();
    run_train("after_reset", vecs[1]);
    seq_start_busy();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
